// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM-state and width definitions for the sequential ALU.
package alu_seq_pkg;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPC_W-1:0] OP_SLL   = 4'd3;
  localparam logic [OPC_W-1:0] OP_SRL   = 4'd4;
  localparam logic [OPC_W-1:0] OP_SLTU  = 4'd5;
  localparam logic [OPC_W-1:0] OP_MVNZ  = 4'd6;
  localparam logic [OPC_W-1:0] OP_PASSB = 4'd7;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd8;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd9;
  localparam logic [OPC_W-1:0] OP_SRA   = 4'd10;
  localparam logic [OPC_W-1:0] OP_SLTS  = 4'd11;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, WIDTH steps.
// Product outputs show the value the current step produces, so the caller can register it on the final step.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_prod_lo,
  output logic [WIDTH-1:0] o_prod_hi,
  output logic             o_last
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  // {hi,lo} starts as {0,multiplier}; each step adds the multiplicand to hi and shifts right.
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    w_hi_next = w_sum[WIDTH:1];
    w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_hi    <= '0;
      r_lo    <= i_mplier;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_prod_lo = w_lo_next;
  assign o_prod_hi = w_hi_next;
  assign o_last    = (r_cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; single-cycle ops finish in one
// cycle, MUL iterates WIDTH cycles in the alu_mul_iter sub-module.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [OPC_W-1:0] controle,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opG,
  output logic [WIDTH-1:0] dout,
  output logic             done,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);
  state_t           r_state;
  state_t           w_state_next;
  logic             w_issue_alu;
  logic             w_mul_load;
  logic             w_mul_step;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_shift_big;

  logic [WIDTH-1:0] r_dout;
  logic             r_done;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk    (Clock),
    .i_rst_n  (Resetn),
    .i_load   (w_mul_load),
    .i_step   (w_mul_step),
    .i_mcand  (opA),
    .i_mplier (opB),
    .o_prod_lo(w_mul_lo),
    .o_prod_hi(w_mul_hi),
    .o_last   (w_mul_last)
  );

  always_comb begin
    w_sum       = {1'b0, opA} + {1'b0, opB};
    w_diff      = {1'b0, opA} - {1'b0, opB};
    w_shift_big = (opB >= WIDTH'(WIDTH));
    w_res       = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    case (controle)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (opA[WIDTH-1] == opB[WIDTH-1]) && (w_sum[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (opA[WIDTH-1] != opB[WIDTH-1]) && (w_diff[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND:   w_res = opA & opB;
      OP_SLL:   w_res = w_shift_big ? '0 : (opA << opB);
      OP_SRL:   w_res = w_shift_big ? '0 : (opA >> opB);
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (opA < opB)};
      OP_MVNZ:  w_res = (opG == '0) ? opA : opB;
      OP_PASSB: w_res = opB;
      OP_OR:    w_res = opA | opB;
      OP_XOR:   w_res = opA ^ opB;
      OP_SRA:   w_res = w_shift_big ? {WIDTH{opA[WIDTH-1]}} : WIDTH'($signed(opA) >>> opB);
      OP_SLTS:  w_res = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // start is only looked at in IDLE, so a request during a multiply is dropped.
  always_comb begin
    w_state_next = r_state;
    w_issue_alu  = 1'b0;
    w_mul_load   = 1'b0;
    w_mul_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (controle == OP_MUL) begin
            w_mul_load   = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_issue_alu  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_mul_step = 1'b1;
        if (w_mul_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_dout <= '0;
      r_done <= 1'b0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue_alu) begin
        r_dout <= w_res;
        r_done <= 1'b1;
        r_z    <= (w_res == '0);
        r_n    <= w_res[WIDTH-1];
        r_c    <= w_c;
        r_v    <= w_v;
      end else if (w_mul_step && w_mul_last) begin
        r_dout <= w_mul_lo;
        r_done <= 1'b1;
        r_z    <= (w_mul_lo == '0);
        r_n    <= w_mul_lo[WIDTH-1];
        r_c    <= (w_mul_hi != '0);
        r_v    <= 1'b0;
      end
    end
  end

  assign dout   = r_dout;
  assign done   = r_done;
  assign busy   = (r_state == ST_MUL);
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;
endmodule
